// File: rtl/keccak_squeeze_serializer_if.sv
// Output word stream of the Keccak squeeze serializer: one 64-bit lane per
// valid/ready transfer.
interface keccak_squeeze_serializer_if #(
  parameter int BW_WORD = 64
);
  logic [BW_WORD-1:0] o_word;
  logic               o_word_valid;
  logic               i_word_ready;

  modport master (output o_word, output o_word_valid, input i_word_ready);
  modport slave  (input o_word, input o_word_valid, output i_word_ready);
endinterface

// File: rtl/keccak_squeeze_serializer.sv
// Squeeze-side reader for Keccak-f[1600]: captures a permuted state and streams
// its rate lanes as 64-bit words, requesting more permutations as needed.
module keccak_squeeze_serializer #(
  parameter int BW_DATA = 1600,
  parameter int BW_WORD = 64,
  parameter int BW_CNT  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [BW_CNT-1:0]  i_nwords,
  input  logic [BW_DATA-1:0] i_state,
  input  logic               i_state_valid,
  output logic               o_state_ready,
  output logic               o_perm_req,
  output logic               o_done,
  keccak_squeeze_serializer_if.master word_if
);

  localparam int N_LANES = BW_DATA / BW_WORD;
  localparam int BW_IDX  = $clog2(N_LANES);

  typedef enum logic [1:0] {IDLE, WAIT_ST, SEND, DONE} state_t;

  state_t              state_reg, state_next;
  logic                mode_reg, mode_next;
  logic [BW_CNT-1:0]   remaining_reg, remaining_next;
  logic [BW_IDX-1:0]   lane_idx_reg, lane_idx_next;
  logic                perm_req_reg, perm_req_next;
  logic                capture;
  logic [BW_IDX-1:0]   rate_last;
  logic [BW_WORD-1:0]  lane_word [N_LANES];

  // One register per lane; all lanes load together when a state is accepted.
  generate
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
      logic [BW_WORD-1:0] lane_reg;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          lane_reg <= '0;
        end else if (capture) begin
          lane_reg <= i_state[gi*BW_WORD +: BW_WORD];
        end
      end
      assign lane_word[gi] = lane_reg;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      mode_reg      <= 1'b0;
      remaining_reg <= '0;
      lane_idx_reg  <= '0;
      perm_req_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      remaining_reg <= remaining_next;
      lane_idx_reg  <= lane_idx_next;
      perm_req_reg  <= perm_req_next;
    end
  end

  assign rate_last = mode_reg ? BW_IDX'(16) : BW_IDX'(20);

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    remaining_next = remaining_reg;
    lane_idx_next  = lane_idx_reg;
    perm_req_next  = 1'b0;
    capture        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          if (i_nwords != '0) begin
            mode_next      = i_mode;
            remaining_next = i_nwords;
            perm_req_next  = 1'b1;
            state_next     = WAIT_ST;
          end else begin
            state_next = DONE;
          end
        end
      end
      WAIT_ST: begin
        if (i_state_valid) begin
          capture       = 1'b1;
          lane_idx_next = '0;
          state_next    = SEND;
        end
      end
      SEND: begin
        if (word_if.i_word_ready) begin
          remaining_next = remaining_reg - BW_CNT'(1);
          lane_idx_next  = lane_idx_reg + BW_IDX'(1);
          // Finishing the request wins over running out of rate lanes.
          if (remaining_reg == BW_CNT'(1)) begin
            state_next = DONE;
          end else if (lane_idx_reg == rate_last) begin
            perm_req_next = 1'b1;
            state_next    = WAIT_ST;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_state_ready        = (state_reg == WAIT_ST);
  assign o_perm_req           = perm_req_reg;
  assign o_done               = (state_reg == DONE);
  assign word_if.o_word_valid = (state_reg == SEND);
  assign word_if.o_word       = (state_reg == SEND) ? lane_word[lane_idx_reg] : '0;

endmodule

// File: tb/tb_keccak_squeeze_serializer.sv
// Randomized bench for keccak_squeeze_serializer: a permutation-core stand-in
// feeds states and an expected-word queue is built from each block's rate lanes.
module tb_keccak_squeeze_serializer;

  logic          clk;
  logic          rst;
  logic          start;
  logic          mode;
  logic [15:0]   nwords;
  logic [1599:0] st;
  logic          st_valid;
  logic          state_ready;
  logic          perm_req;
  logic          done;
  int            checks = 0;
  int            errors = 0;
  int            pat_tab [6] = '{1, 0, 0, 1, 0, 1};

  keccak_squeeze_serializer_if #(.BW_WORD(64)) wif ();

  keccak_squeeze_serializer #(.BW_DATA(1600), .BW_WORD(64), .BW_CNT(16)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_mode        (mode),
    .i_nwords      (nwords),
    .i_state       (st),
    .i_state_valid (st_valid),
    .o_state_ready (state_ready),
    .o_perm_req    (perm_req),
    .o_done        (done),
    .word_if       (wif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_state_ready"}, state_ready, 0);
    chk({name, "_perm_req"}, perm_req, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_word_valid"}, wif.o_word_valid, 0);
    chk({name, "_word"}, wif.o_word, 0);
  endtask

  // lstyle 1: block b lane k = 0x100*b + k; lstyle 0: random lanes.
  // rstyle 0: ready always 1; 1: fixed 1,0,0,1,0,1 pattern; 2: random.
  task automatic run_job(input logic m, input int nw, input int rstyle,
                         input int lstyle, input bit poke);
    logic [63:0]   exp_q [$];
    logic [63:0]   exp_w;
    logic [63:0]   prev_word;
    logic [1599:0] blk_st;
    int  rate      = m ? 17 : 21;
    int  got       = 0;
    int  nperm     = 0;
    int  dly       = 0;
    int  cyc       = 0;
    int  last_xfer = -100;
    bit  have      = 0;
    bit  cap_prev  = 0;
    bit  prev_stall = 0;
    bit  fin       = 0;
    bit  any_valid = 0;
    bit  rdy;
    int  exp_perm;

    @(negedge clk);
    start  = 1'b1;
    mode   = m;
    nwords = nw[15:0];
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      case (rstyle)
        0:       rdy = 1'b1;
        1:       rdy = pat_tab[(cyc - 1) % 6] != 0;
        default: rdy = ($urandom_range(0, 9) < 7);
      endcase
      wif.i_word_ready = rdy;

      if (cap_prev) chk("first_word_latency", wif.o_word_valid, 1);
      cap_prev = 0;
      if (prev_stall) begin
        chk("stall_valid", wif.o_word_valid, 1);
        chk("stall_word", wif.o_word, prev_word);
      end
      if (wif.o_word_valid) any_valid = 1;

      if (perm_req) begin
        for (int k = 0; k < 25; k++) begin
          if (lstyle == 1) blk_st[k*64 +: 64] = 64'(nperm * 256 + k);
          else             blk_st[k*64 +: 64] = {$urandom, $urandom};
          if (k < rate) exp_q.push_back(blk_st[k*64 +: 64]);
        end
        nperm++;
        have = 1;
        dly  = (rstyle == 0) ? 0 : $urandom_range(0, 2);
      end

      if (wif.o_word_valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", wif.o_word_valid, 0);
        end else begin
          exp_w = exp_q.pop_front();
          chk("word", wif.o_word, exp_w);
        end
        if (lstyle == 1) chk("word_literal", wif.o_word, 64'((got / rate) * 256 + got % rate));
        if (rstyle == 0 && got > 0 && (got % rate) != 0) chk("back_to_back", 64'(cyc - last_xfer), 1);
        got++;
        last_xfer = cyc;
      end
      prev_stall = wif.o_word_valid && !rdy;
      prev_word  = wif.o_word;

      if (done) begin
        chk("done_word_count", 64'(got), 64'(nw));
        if (nw > 0) chk("done_after_last_word", 64'(cyc - last_xfer), 1);
        else        chk("zero_done_latency", 64'(cyc), 1);
        fin = 1;
      end

      // Start pulses while words are streaming must be ignored.
      if (poke && wif.o_word_valid && $urandom_range(0, 3) == 0) begin
        start  = 1'b1;
        mode   = ~m;
        nwords = 16'($urandom_range(1, 60));
      end

      st_valid = 1'b0;
      if (have) begin
        if (dly > 0) begin
          dly--;
        end else if (state_ready) begin
          st       = blk_st;
          st_valid = 1'b1;
          have     = 0;
          cap_prev = 1;
        end
      end
    end
    if (!fin) chk("job_timeout", 64'(cyc), 64'(0));
    exp_perm = (nw == 0) ? 0 : (nw + rate - 1) / rate;
    chk("perm_req_count", 64'(nperm), 64'(exp_perm));
    if (nw == 0) chk("zero_no_word_valid", any_valid, 0);
    @(negedge clk);
    start = 1'b0;
    chk_idle_outputs("after_done");
    $display("job mode=%0d nwords=%0d ready_style=%0d words=%0d perm_reqs=%0d cycles=%0d",
             m, nw, rstyle, got, nperm, cyc);
  endtask

  initial begin
    int xfers;
    int budget;
    rst = 1'b1; start = 1'b0; mode = 1'b0; nwords = '0;
    st = '0; st_valid = 1'b0; wif.i_word_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // Abort a SHAKE128 job with a two-cycle reset in the middle of SEND.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; nwords = 16'd21; wif.i_word_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 25; k++) st[k*64 +: 64] = 64'(k);
    st_valid = 1'b1;
    xfers  = 0;
    budget = 0;
    while (xfers < 5 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (!state_ready) st_valid = 1'b0;
      if (wif.o_word_valid) xfers++;
    end
    chk("reset_setup_words", 64'(xfers), 5);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_idle_outputs("post_reset");
    end
    $display("reset abort checked");

    run_job(1'b0, 21, 0, 1, 0);
    run_job(1'b1, 20, 0, 1, 0);
    run_job(1'b0, 10, 1, 1, 0);
    run_job(1'b0, 0,  0, 0, 0);
    run_job(1'b1, 40, 1, 0, 1);
    run_job(1'b0, 43, 2, 1, 1);
    for (int j = 0; j < 16; j++) begin
      run_job(1'($urandom_range(0, 1)), (j % 5 == 0) ? 0 : $urandom_range(1, 50),
              2, 0, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
